bmr_tdee_bt_debounce: RTL and testbench

BMR_TDEE_BT_DEBOUNCE -- requirements
Module: bmr_tdee_bt_debounce

---
 rtl/bmr_tdee_bt_debounce.sv | 64 ++++++
 tb/tb_bmr_tdee_bt_debounce.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/bmr_tdee_bt_debounce.sv
// Per-channel pushbutton debouncer: polarity normalise, 2-flop synchroniser,
// stability counter, and registered press/release pulses aligned with the level change.
module bmr_tdee_bt_debounce #(
   parameter int unsigned WIDTH           = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter bit          ACTIVE_LOW      = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] key_raw,
   output logic [WIDTH-1:0] bt_level,
   output logic [WIDTH-1:0] bt_press,
   output logic [WIDTH-1:0] bt_release
);

   localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] w_key_norm;
   logic [WIDTH-1:0] r_sync1;
   logic [WIDTH-1:0] r_sync2;
   logic [WIDTH-1:0] r_stable;
   logic [WIDTH-1:0] r_press;
   logic [WIDTH-1:0] r_release;
   logic [CW-1:0]    r_cnt [WIDTH];

   assign w_key_norm = ACTIVE_LOW ? ~key_raw : key_raw;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1   <= '0;
         r_sync2   <= '0;
         r_stable  <= '0;
         r_press   <= '0;
         r_release <= '0;
         for (int unsigned i = 0; i < WIDTH; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         r_sync1   <= w_key_norm;
         r_sync2   <= r_sync1;
         r_press   <= '0;
         r_release <= '0;
         for (int unsigned i = 0; i < WIDTH; i++) begin
            if (r_sync2[i] == r_stable[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == CNT_LAST) begin
               // Pulses register on the same edge as the level so they coincide with it.
               r_stable[i]  <= r_sync2[i];
               r_press[i]   <= r_sync2[i];
               r_release[i] <= ~r_sync2[i];
               r_cnt[i]     <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + CW'(1);
            end
         end
      end
   end

   assign bt_level   = r_stable;
   assign bt_press   = r_press;
   assign bt_release = r_release;

endmodule

// File: tb/tb_bmr_tdee_bt_debounce.sv
// Directed bench for bmr_tdee_bt_debounce with DEBOUNCE_CYCLES=4, ACTIVE_LOW=1, WIDTH=2.
module tb_bmr_tdee_bt_debounce;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] key_raw;
   logic [1:0] bt_level;
   logic [1:0] bt_press;
   logic [1:0] bt_release;

   int n_tests = 0;
   int n_fail  = 0;
   int n_press0 = 0, n_press1 = 0, n_rel0 = 0, n_rel1 = 0, n_overlap = 0;

   bmr_tdee_bt_debounce #(
      .WIDTH           (2),
      .DEBOUNCE_CYCLES (4),
      .ACTIVE_LOW      (1'b1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .key_raw    (key_raw),
      .bt_level   (bt_level),
      .bt_press   (bt_press),
      .bt_release (bt_release)
   );

   always #5 clk = ~clk;

   // Pulse tally sampled mid-cycle, away from the active edge
   always @(negedge clk) begin
      if (bt_press[0])   n_press0++;
      if (bt_press[1])   n_press1++;
      if (bt_release[0]) n_rel0++;
      if (bt_release[1]) n_rel1++;
      if ((bt_press & bt_release) != 2'b00) n_overlap++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      reset   = 1'b1;
      key_raw = 2'b11;
      tick(3);
      chk("rst_level",   32'(bt_level),   32'h0);
      chk("rst_press",   32'(bt_press),   32'h0);
      chk("rst_release", 32'(bt_release), 32'h0);
      reset = 1'b0;

      // Idle with both keys released
      tick(20);
      chk("idle_level", 32'(bt_level), 32'h0);
      chk("idle_press_cnt", 32'(n_press0 + n_press1), 32'h0);

      // Single press on bit 0
      key_raw = 2'b10;
      tick(5);
      chk("p0_e5_level", 32'(bt_level), 32'h0);
      chk("p0_e5_press", 32'(bt_press), 32'h0);
      tick(1);
      chk("p0_e6_level", 32'(bt_level), 32'h1);
      chk("p0_e6_press", 32'(bt_press), 32'h1);
      tick(1);
      chk("p0_e7_press", 32'(bt_press), 32'h0);
      chk("p0_e7_level", 32'(bt_level), 32'h1);
      tick(10);
      chk("p0_hold_level", 32'(bt_level), 32'h1);

      // Release bit 0
      key_raw = 2'b11;
      tick(5);
      chk("r0_e5_level", 32'(bt_level), 32'h1);
      tick(1);
      chk("r0_e6_level",   32'(bt_level),   32'h0);
      chk("r0_e6_release", 32'(bt_release), 32'h1);
      chk("r0_e6_press",   32'(bt_press),   32'h0);
      tick(1);
      chk("r0_e7_release", 32'(bt_release), 32'h0);
      tick(5);

      // Three-cycle glitches on bit 1 must be rejected
      for (int r = 0; r < 5; r++) begin
         key_raw = 2'b01;
         for (int k = 0; k < 3; k++) begin
            tick(1);
            chk("glitch_level_lo", 32'(bt_level), 32'h0);
         end
         key_raw = 2'b11;
         for (int k = 0; k < 3; k++) begin
            tick(1);
            chk("glitch_level_hi", 32'(bt_level), 32'h0);
         end
      end
      tick(6);
      chk("glitch_level_end", 32'(bt_level), 32'h0);
      chk("glitch_press1_cnt", 32'(n_press1), 32'h0);

      // Both keys together
      key_raw = 2'b00;
      tick(5);
      chk("both_e5_level", 32'(bt_level), 32'h0);
      tick(1);
      chk("both_e6_level", 32'(bt_level), 32'h3);
      chk("both_e6_press", 32'(bt_press), 32'h3);
      tick(1);
      chk("both_e7_press", 32'(bt_press), 32'h0);
      tick(43);
      chk("both_hold_level", 32'(bt_level), 32'h3);
      key_raw = 2'b11;
      tick(5);
      chk("both_r5_level",   32'(bt_level),   32'h3);
      chk("both_r5_release", 32'(bt_release), 32'h0);
      tick(1);
      chk("both_r6_level",   32'(bt_level),   32'h0);
      chk("both_r6_release", 32'(bt_release), 32'h3);
      tick(1);
      chk("both_r7_release", 32'(bt_release), 32'h0);
      tick(5);

      // Partial count discarded by reset; held key re-qualifies afterwards
      key_raw = 2'b10;
      tick(3);
      chk("pre_rst_level", 32'(bt_level), 32'h0);
      reset = 1'b1;
      tick(1);
      chk("mid_rst_level", 32'(bt_level), 32'h0);
      chk("mid_rst_press", 32'(bt_press), 32'h0);
      reset = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         tick(1);
         chk("post_rst_early_level", 32'(bt_level), 32'h0);
         chk("post_rst_early_press", 32'(bt_press), 32'h0);
      end
      tick(1);
      chk("post_rst_e6_level", 32'(bt_level), 32'h1);
      chk("post_rst_e6_press", 32'(bt_press), 32'h1);
      tick(1);
      chk("post_rst_e7_press", 32'(bt_press), 32'h0);
      tick(20);
      chk("post_rst_hold_level", 32'(bt_level), 32'h1);

      // Total pulse tallies across the run
      chk("tally_press0",  32'(n_press0),  32'd3);
      chk("tally_press1",  32'(n_press1),  32'd1);
      chk("tally_rel0",    32'(n_rel0),    32'd2);
      chk("tally_rel1",    32'(n_rel1),    32'd1);
      chk("tally_overlap", 32'(n_overlap), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
